// File: rtl/asyn_fifo_pkg.sv
// Shared types and helpers for the dual-clock FIFO: Gray conversion, FWFT mode constants,
// and the output-stage state encoding.
package asyn_fifo_pkg;

  localparam int unsigned GrayMaxW = 32;
  localparam int unsigned FwftStd  = 0;
  localparam int unsigned FwftOn   = 1;

  typedef enum logic {StEmptyOut, StHolding} out_state_e;

  // Callers zero-extend narrower pointers; the low bits of the result are exact.
  function automatic logic [GrayMaxW-1:0] bin2gray(input logic [GrayMaxW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GrayMaxW-1:0] gray2bin(input logic [GrayMaxW-1:0] g);
    logic [GrayMaxW-1:0] b;
    for (int i = 0; i < GrayMaxW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_out_stage.sv
// Output data register for the FIFO read side; decides when a RAM word is consumed and
// holds it in rdata/rvalid, in either standard or first-word-fall-through mode.
module rd_out_stage
  import asyn_fifo_pkg::*;
#(
  parameter int unsigned FWFT       = FwftStd,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rinc,
  input  logic                  i_rempty,
  input  logic                  i_mem_empty,
  input  logic [DATA_WIDTH-1:0] i_rdata_mem,
  output logic                  o_pop_mem,
  output logic                  o_rvalid,
  output logic                  o_rvalid_next,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  out_state_e            r_state;
  out_state_e            w_state_next;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StEmptyOut;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (w_pop) begin
      r_rdata <= i_rdata_mem;
    end
  end

  // Standard mode shows a word for one cycle; FWFT keeps it until the consumer pops it.
  always_comb begin
    if (FWFT != FwftStd) begin
      w_pop = ~i_mem_empty & ((r_state == StEmptyOut) | i_rinc);
    end else begin
      w_pop = i_rinc & ~i_rempty;
    end
    w_state_next = StEmptyOut;
    if (w_pop) begin
      w_state_next = StHolding;
    end else if ((FWFT != FwftStd) && (r_state == StHolding) && !i_rinc) begin
      w_state_next = StHolding;
    end
  end

  always_comb begin
    o_pop_mem     = w_pop;
    o_rvalid      = (r_state == StHolding);
    o_rvalid_next = (w_state_next == StHolding);
    o_rdata       = r_rdata;
  end

endmodule

// File: rtl/rd_ctrl_ext.sv
// Read-side controller for the dual-clock FIFO: Gray/binary read pointer, empty, level,
// almost-empty and underflow flags, plus a standard or FWFT output register.
module rd_ctrl_ext
  import asyn_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FWFT          = FwftStd,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  i_rclk,
  input  logic                  i_rrst_n,
  input  logic                  i_rinc,
  input  logic [ADDR_WIDTH:0]   i_rq2_wptr,
  input  logic [DATA_WIDTH-1:0] i_rdata_mem,
  output logic [ADDR_WIDTH:0]   o_rptr,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_rempty,
  output logic                  o_raempty,
  output logic [ADDR_WIDTH:0]   o_rlevel,
  output logic                  o_runderflow
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  logic [PtrW-1:0]     r_rbin;
  logic [PtrW-1:0]     r_rptr;
  logic [PtrW-1:0]     r_rlevel;
  logic                r_rempty;
  logic                r_raempty;
  logic                r_runderflow;

  logic [GrayMaxW-1:0] w_wbin_full;
  logic [GrayMaxW-1:0] w_gray_full;
  logic [PtrW-1:0]     w_wbin;
  logic [PtrW-1:0]     w_rbin_next;
  logic [PtrW-1:0]     w_rgray_next;
  logic [PtrW-1:0]     w_level_next;
  logic                w_mem_empty;
  logic                w_pop_mem;
  logic                w_rvalid_next;
  logic                w_unused;

  rd_out_stage #(
    .FWFT       (FWFT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .i_clk         (i_rclk),
    .i_rst_n       (i_rrst_n),
    .i_rinc        (i_rinc),
    .i_rempty      (r_rempty),
    .i_mem_empty   (w_mem_empty),
    .i_rdata_mem   (i_rdata_mem),
    .o_pop_mem     (w_pop_mem),
    .o_rvalid      (o_rvalid),
    .o_rvalid_next (w_rvalid_next),
    .o_rdata       (o_rdata)
  );

  always_comb begin
    w_wbin_full  = gray2bin(GrayMaxW'(i_rq2_wptr));
    w_wbin       = w_wbin_full[PtrW-1:0];
    w_mem_empty  = (r_rptr == i_rq2_wptr);
    w_rbin_next  = r_rbin + PtrW'(w_pop_mem);
    w_gray_full  = bin2gray(GrayMaxW'(w_rbin_next));
    w_rgray_next = w_gray_full[PtrW-1:0];
    // The held output word counts as stored in FWFT mode, so level can reach DEPTH+1.
    w_level_next = w_wbin - w_rbin_next + ((FWFT != FwftStd) ? PtrW'(w_rvalid_next) : '0);
    w_unused     = ^{w_wbin_full[GrayMaxW-1:PtrW], w_gray_full[GrayMaxW-1:PtrW]};
  end

  always_ff @(posedge i_rclk or negedge i_rrst_n) begin
    if (!i_rrst_n) begin
      r_rbin       <= '0;
      r_rptr       <= '0;
      r_rlevel     <= '0;
      r_rempty     <= 1'b1;
      r_raempty    <= 1'b1;
      r_runderflow <= 1'b0;
    end else begin
      r_rbin       <= w_rbin_next;
      r_rptr       <= w_rgray_next;
      r_rlevel     <= w_level_next;
      r_rempty     <= (FWFT != FwftStd) ? ~w_rvalid_next : (w_rgray_next == i_rq2_wptr);
      r_raempty    <= (w_level_next <= PtrW'(AEMPTY_THRESH));
      r_runderflow <= i_rinc & r_rempty;
    end
  end

  assign o_rptr       = r_rptr;
  assign o_raddr      = r_rbin[ADDR_WIDTH-1:0];
  assign o_rempty     = r_rempty;
  assign o_raempty    = r_raempty;
  assign o_rlevel     = r_rlevel;
  assign o_runderflow = r_runderflow;

endmodule

// File: tb/tb_rd_ctrl_ext.sv
// Self-checking bench for rd_ctrl_ext: one standard and one FWFT instance side by side,
// each fed by its own write-pointer model and combinational RAM model.
module tb_rd_ctrl_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rinc0, rinc1;
  logic [4:0]  wb0, wb1, wg0, wg1;
  logic [31:0] mem [16];
  logic [31:0] rdm0, rdm1;

  logic [4:0]  rptr0, rptr1, rlevel0, rlevel1;
  logic [3:0]  raddr0, raddr1;
  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, rempty0, rempty1, raempty0, raempty1, runder0, runder1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  assign wg0  = wb0 ^ (wb0 >> 1);
  assign wg1  = wb1 ^ (wb1 >> 1);
  assign rdm0 = mem[raddr0];
  assign rdm1 = mem[raddr1];

  rd_ctrl_ext #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .FWFT(0), .AEMPTY_THRESH(2)) u_std (
    .i_rclk(clk), .i_rrst_n(rst_n), .i_rinc(rinc0), .i_rq2_wptr(wg0), .i_rdata_mem(rdm0),
    .o_rptr(rptr0), .o_raddr(raddr0), .o_rdata(rdata0), .o_rvalid(rvalid0),
    .o_rempty(rempty0), .o_raempty(raempty0), .o_rlevel(rlevel0), .o_runderflow(runder0)
  );

  rd_ctrl_ext #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .FWFT(1), .AEMPTY_THRESH(2)) u_fwft (
    .i_rclk(clk), .i_rrst_n(rst_n), .i_rinc(rinc1), .i_rq2_wptr(wg1), .i_rdata_mem(rdm1),
    .o_rptr(rptr1), .o_raddr(raddr1), .o_rdata(rdata1), .o_rvalid(rvalid1),
    .o_rempty(rempty1), .o_raempty(raempty1), .o_rlevel(rlevel1), .o_runderflow(runder1)
  );

  // Scoreboard: standard mode delivers a word whenever rvalid is high; FWFT on rvalid & rinc.
  always @(negedge clk) begin : sb_monitor
    logic [31:0] e;
    if (rst_n === 1'b1) begin
      if (rvalid0 === 1'b1) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL sb_std: got word %h, required no word", rdata0);
        end else begin
          e = q0.pop_front();
          if (rdata0 !== e) begin
            errors++;
            $display("FAIL sb_std: got %h, required %h", rdata0, e);
          end
        end
      end
      if (rvalid1 === 1'b1 && rinc1 === 1'b1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb_fwft: got word %h, required no word", rdata1);
        end else begin
          e = q1.pop_front();
          if (rdata1 !== e) begin
            errors++;
            $display("FAIL sb_fwft: got %h, required %h", rdata1, e);
          end
        end
      end
    end
  end

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push0(input int n);
    for (int i = 0; i < n; i++) begin
      q0.push_back(32'hA000_0000 + 32'(wb0[3:0]));
      wb0 = wb0 + 5'd1;
    end
  endtask

  task automatic push1(input int n);
    for (int i = 0; i < n; i++) begin
      q1.push_back(32'hA000_0000 + 32'(wb1[3:0]));
      wb1 = wb1 + 5'd1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rinc0 = 1'b0;
    rinc1 = 1'b0;
    wb0   = '0;
    wb1   = '0;
    q0.delete();
    q1.delete();
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    push0(4);
    push1(4);
    tick(1);
    rinc0 = 1'b1;
    rinc1 = 1'b1;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rptr0, rdata0, rvalid0, rempty0, raempty0, rlevel0, runder0} !==
        {5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_std: got rptr=%h rdata=%h v=%b e=%b ae=%b lvl=%0d uf=%b, required 0 0 0 1 1 0 0",
               rptr0, rdata0, rvalid0, rempty0, raempty0, rlevel0, runder0);
    end
    checks++;
    if ({rptr1, rdata1, rvalid1, rempty1, raempty1, rlevel1, runder1} !==
        {5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_fwft: got rptr=%h rdata=%h v=%b e=%b ae=%b lvl=%0d uf=%b, required 0 0 0 1 1 0 0",
               rptr1, rdata1, rvalid1, rempty1, raempty1, rlevel1, runder1);
    end
    do_reset();
  endtask

  task automatic test_std_basic();
    do_reset();
    push0(1);
    tick(1);
    checks++;
    if ({rempty0, rlevel0, raempty0, rvalid0} !== {1'b0, 5'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL std_avail: got e=%b lvl=%0d ae=%b v=%b, required 0 1 1 0",
               rempty0, rlevel0, raempty0, rvalid0);
    end
    rinc0 = 1'b1;
    tick(1);
    rinc0 = 1'b0;
    checks++;
    if ({rvalid0, rdata0, rempty0, rlevel0} !== {1'b1, 32'hA000_0000, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL std_read: got v=%b d=%h e=%b lvl=%0d, required 1 a0000000 1 0",
               rvalid0, rdata0, rempty0, rlevel0);
    end
    tick(1);
    checks++;
    if (rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL std_valid_drop: got %b, required 0", rvalid0);
    end
  endtask

  task automatic test_fwft_basic();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hA000_0001;
    exp_d[1] = 32'hA000_0002;
    do_reset();
    push1(3);
    tick(1);
    checks++;
    if ({rvalid1, rdata1, rempty1, rlevel1} !== {1'b1, 32'hA000_0000, 1'b0, 5'd3}) begin
      errors++;
      $display("FAIL fwft_fall: got v=%b d=%h e=%b lvl=%0d, required 1 a0000000 0 3",
               rvalid1, rdata1, rempty1, rlevel1);
    end
    rinc1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      checks++;
      if ({rvalid1, rdata1, rlevel1} !== {1'b1, exp_d[i], 5'(2 - i)}) begin
        errors++;
        $display("FAIL fwft_pop%0d: got v=%b d=%h lvl=%0d, required 1 %h %0d",
                 i, rvalid1, rdata1, rlevel1, exp_d[i], 2 - i);
      end
    end
    tick(1);
    rinc1 = 1'b0;
    checks++;
    if ({rvalid1, rempty1, rlevel1, runder1} !== {1'b0, 1'b1, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL fwft_drain: got v=%b e=%b lvl=%0d uf=%b, required 0 1 0 0",
               rvalid1, rempty1, rlevel1, runder1);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] base;
    logic [4:0] e1;
    bit         seen0, seen1;
    seen0 = 1'b0;
    seen1 = 1'b0;
    base  = '0;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      push0(16);
      push1(16);
      tick(2);
      checks++;
      if ({rlevel0, rempty0, rlevel1, rvalid1} !== {5'd16, 1'b0, 5'd16, 1'b1}) begin
        errors++;
        $display("FAIL wrap_full%0d: got std lvl=%0d e=%b fwft lvl=%0d v=%b, required 16 0 16 1",
                 r, rlevel0, rempty0, rlevel1, rvalid1);
      end
      rinc0 = 1'b1;
      rinc1 = 1'b1;
      for (int i = 1; i <= 16; i++) begin
        tick(1);
        e1 = (i < 15) ? base + 5'(i + 1) : base + 5'd16;
        if (rptr0 === 5'b11000) seen0 = 1'b1;
        if (rptr1 === 5'b11000) seen1 = 1'b1;
        checks++;
        if (rptr0 !== g5(base + 5'(i)) || rptr1 !== g5(e1)) begin
          errors++;
          $display("FAIL wrap_rptr r%0d i%0d: got %b/%b, required %b/%b",
                   r, i, rptr0, rptr1, g5(base + 5'(i)), g5(e1));
        end
      end
      rinc0 = 1'b0;
      rinc1 = 1'b0;
      checks++;
      if ({rlevel0, rempty0, rlevel1, rempty1} !== {5'd0, 1'b1, 5'd0, 1'b1}) begin
        errors++;
        $display("FAIL wrap_empty%0d: got lvl=%0d e=%b / lvl=%0d e=%b, required 0 1 0 1",
                 r, rlevel0, rempty0, rlevel1, rempty1);
      end
      base = base + 5'd16;
    end
    tick(1);
    checks++;
    if (!(seen0 && seen1) || q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL wrap_summary: got seen=%b%b left=%0d/%0d, required 11 0/0",
               seen0, seen1, q0.size(), q1.size());
    end
  endtask

  task automatic test_thresholds();
    do_reset();
    push0(3);
    tick(2);
    checks++;
    if ({rlevel0, raempty0} !== {5'd3, 1'b0}) begin
      errors++;
      $display("FAIL thr_level3: got lvl=%0d ae=%b, required 3 0", rlevel0, raempty0);
    end
    rinc0 = 1'b1;
    tick(1);
    rinc0 = 1'b0;
    checks++;
    if ({rlevel0, raempty0} !== {5'd2, 1'b1}) begin
      errors++;
      $display("FAIL thr_level2: got lvl=%0d ae=%b, required 2 1", rlevel0, raempty0);
    end
    do_reset();
    push0(16);
    push1(16);
    tick(2);
    checks++;
    if ({rlevel0, raempty0, rlevel1, rvalid1, rptr0} !== {5'd16, 1'b0, 5'd16, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL thr_full: got std lvl=%0d ae=%b fwft lvl=%0d v=%b rptr0=%b, required 16 0 16 1 0",
               rlevel0, raempty0, rlevel1, rvalid1, rptr0);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    tick(1);
    rinc0 = 1'b1;
    rinc1 = 1'b1;
    tick(1);
    rinc0 = 1'b0;
    rinc1 = 1'b0;
    checks++;
    if ({runder0, rptr0, rvalid0, runder1, rptr1, rvalid1} !==
        {1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL uf_pulse: got uf=%b rptr=%b v=%b / uf=%b rptr=%b v=%b, required 1 0 0 1 0 0",
               runder0, rptr0, rvalid0, runder1, rptr1, rvalid1);
    end
    tick(1);
    checks++;
    if ({runder0, runder1, rempty0, rempty1} !== {1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL uf_clear: got uf=%b%b e=%b%b, required 00 11", runder0, runder1, rempty0, rempty1);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
    rst_n = 1'b0;
    rinc0 = 1'b0;
    rinc1 = 1'b0;
    wb0   = '0;
    wb1   = '0;
    test_reset();
    test_std_basic();
    test_fwft_basic();
    test_wrap();
    test_thresholds();
    test_underflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
